// File: rtl/shift_sequencer_if.sv
// Operand/shifter-field request bus and result bus of the shift sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: none here; master must watch busy before issuing start.
interface shift_sequencer_if;
    logic        start;
    logic        flush;
    logic [31:0] Val_Rm;
    logic [11:0] Shift_operand;
    logic        Imm;
    logic        Val2_Src;
    logic        busy;
    logic        done;
    logic [31:0] Val2;

    modport master (
        output start, flush, Val_Rm, Shift_operand, Imm, Val2_Src,
        input  busy, done, Val2
    );

    modport slave (
        input  start, flush, Val_Rm, Shift_operand, Imm, Val2_Src,
        output busy, done, Val2
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-shifter replacement: computes the ARM-style Val2 operand STEP bits per cycle.
// Latency: 1 + ceil(amount/STEP) cycles from the accept edge to the done pulse.
// Backpressure: start is ignored while in SHIFT; busy is a pure state decode usable as a stall.
module shift_sequencer #(
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR, SH_ASR, SH_ROR} shtype_t;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t      state;
    shtype_t     sh_type;
    logic [31:0] work;
    logic [4:0]  remaining;
    logic [31:0] val2_q;

    logic        accept;
    logic        rot_imm;
    logic [31:0] acc_operand;
    logic [4:0]  acc_amount;
    shtype_t     acc_type;

    logic [4:0]  step_amt;
    logic [31:0] work_next;
    logic [4:0]  rem_next;

    // One partial shift of the working value; repeated partial shifts compose
    // to the single full shift because every amount stays below 32.
    function automatic logic [31:0] shift_by(input logic [31:0] v, input shtype_t t,
                                             input logic [4:0] amt);
        logic [31:0] r;
        case (t)
            SH_LSL:  r = v << amt;
            SH_LSR:  r = v >> amt;
            SH_ASR:  r = $unsigned($signed(v) >>> amt);
            default: r = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
        endcase
        return r;
    endfunction

    // Decode the request fields into operand, amount and shift type for the accept cycle.
    always_comb begin
        accept  = bus.start & ~bus.flush & (state != SHIFT);
        rot_imm = bus.Imm | bus.Val2_Src;
        if (rot_imm) begin
            acc_operand = {24'b0, bus.Shift_operand[7:0]};
            acc_amount  = {bus.Shift_operand[11:8], 1'b0};
            acc_type    = SH_ROR;
        end else begin
            acc_operand = bus.Val_Rm;
            acc_amount  = bus.Shift_operand[11:7];
            acc_type    = shtype_t'(bus.Shift_operand[6:5]);
        end
    end

    // Next working value: shift by STEP, or by whatever is left on the final partial step.
    always_comb begin
        step_amt  = (remaining < STEP_AMT) ? remaining : STEP_AMT;
        work_next = shift_by(work, sh_type, step_amt);
        rem_next  = remaining - step_amt;
    end

    // Sequencer FSM; flush wins over everything except reset and leaves Val2 alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh_type   <= SH_LSL;
            work      <= '0;
            remaining <= '0;
            val2_q    <= '0;
        end else if (bus.flush) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    work      <= work_next;
                    remaining <= rem_next;
                    // The last partial shift moves straight to DONE with the result.
                    if (rem_next == 5'd0) begin
                        state  <= DONE;
                        val2_q <= work_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, so back-to-back ops need no bubble.
                    if (accept) begin
                        work      <= acc_operand;
                        remaining <= acc_amount;
                        sh_type   <= acc_type;
                        if (acc_amount == 5'd0) begin
                            state  <= DONE;
                            val2_q <= acc_operand;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.Val2 = val2_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: three sequencers (STEP 1, 2, 4) fed identical stimulus.
// Latency: each result checked against 1 + ceil(amount/STEP).
// Backpressure: exercises start-while-busy, flush and mid-operation reset.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, Imm, Val2_Src;
    logic [31:0] Val_Rm;
    logic [11:0] Shift_operand;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_v2 [3];

    always #5 clk = ~clk;

    shift_sequencer_if bus1 ();
    shift_sequencer_if bus2 ();
    shift_sequencer_if bus4 ();

    assign bus1.start = start;  assign bus2.start = start;  assign bus4.start = start;
    assign bus1.flush = flush;  assign bus2.flush = flush;  assign bus4.flush = flush;
    assign bus1.Imm = Imm;      assign bus2.Imm = Imm;      assign bus4.Imm = Imm;
    assign bus1.Val2_Src = Val2_Src; assign bus2.Val2_Src = Val2_Src; assign bus4.Val2_Src = Val2_Src;
    assign bus1.Val_Rm = Val_Rm; assign bus2.Val_Rm = Val_Rm; assign bus4.Val_Rm = Val_Rm;
    assign bus1.Shift_operand = Shift_operand;
    assign bus2.Shift_operand = Shift_operand;
    assign bus4.Shift_operand = Shift_operand;

    shift_sequencer #(.STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    shift_sequencer #(.STEP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    shift_sequencer #(.STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    logic [31:0] v2 [3];
    logic        dn [3];
    logic        bz [3];
    assign v2[0] = bus1.Val2; assign v2[1] = bus2.Val2; assign v2[2] = bus4.Val2;
    assign dn[0] = bus1.done; assign dn[1] = bus2.done; assign dn[2] = bus4.done;
    assign bz[0] = bus1.busy; assign bz[1] = bus2.busy; assign bz[2] = bus4.busy;

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Reference: decode the fields, then build the result bit by bit from the shift definition.
    function automatic logic [31:0] ref_val2(input logic rot, input logic [31:0] rm,
                                             input logic [11:0] so, output int amt);
        logic [31:0] op;
        logic [31:0] r;
        logic [63:0] dbl;
        int          typ;
        if (rot) begin
            op  = {24'b0, so[7:0]};
            amt = 2 * int'(so[11:8]);
            typ = 3;
        end else begin
            op  = rm;
            amt = int'(so[11:7]);
            typ = int'(so[6:5]);
        end
        dbl = {op, op};
        r   = '0;
        for (int i = 0; i < 32; i++) begin
            case (typ)
                0:       r[i] = (i >= amt) ? op[i - amt] : 1'b0;
                1:       r[i] = (i + amt < 32) ? op[i + amt] : 1'b0;
                2:       r[i] = (i + amt < 32) ? op[i + amt] : op[31];
                default: r[i] = dbl[i + amt];
            endcase
        end
        return r;
    endfunction

    // mode 0: quiet; 1: scramble all inputs after accept; 2: start pulse with new operands in cycle 2
    task automatic run_op(input string name, input logic imm_i, input logic v2s_i,
                          input logic [31:0] rm, input logic [11:0] so,
                          input bit use_fixed, input logic [31:0] fixed_val, input int mode);
        logic [31:0] exp;
        int          amt;
        int          lat;
        bit          seen [3];
        int          seen_k [3];
        exp = ref_val2(imm_i | v2s_i, rm, so, amt);
        if (use_fixed) exp = fixed_val;
        for (int d = 0; d < 3; d++) begin seen[d] = 0; seen_k[d] = 0; end
        @(negedge clk);
        start = 1'b1; Imm = imm_i; Val2_Src = v2s_i; Val_Rm = rm; Shift_operand = so;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (seen[d] && k == seen_k[d] + 1) begin
                    checks++;
                    if (dn[d] !== 1'b0 || bz[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_after_done STEP=%0d: done=%b busy=%b, required 0 0",
                                 name, step_of(d), dn[d], bz[d]);
                    end
                end
                if (!seen[d] && dn[d] === 1'b1) begin
                    seen[d]   = 1;
                    seen_k[d] = k;
                    lat = 1 + (amt + step_of(d) - 1) / step_of(d);
                    checks++;
                    if (k != lat) begin
                        errors++;
                        $display("FAIL %s_latency STEP=%0d: got %0d cycles, required %0d",
                                 name, step_of(d), k, lat);
                    end
                    checks++;
                    if (v2[d] !== exp) begin
                        errors++;
                        $display("FAIL %s_val2 STEP=%0d: got %h, required %h",
                                 name, step_of(d), v2[d], exp);
                    end
                    last_v2[d] = v2[d];
                end
            end
            start = 1'b0;
            if (mode == 1) begin
                Val_Rm = $urandom; Shift_operand = 12'($urandom);
                Imm = 1'($urandom); Val2_Src = 1'($urandom);
            end
            if (mode == 2 && k == 2) begin
                start = 1'b1; Val_Rm = $urandom; Shift_operand = 12'($urandom);
                Imm = 1'b0; Val2_Src = 1'b0;
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!seen[d]) begin
                errors++;
                $display("FAIL %s_timeout STEP=%0d: no done within 40 cycles, required one",
                         name, step_of(d));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; Imm = 1'b0; Val2_Src = 1'b0;
        Val_Rm = '0; Shift_operand = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bz[d] !== 1'b0 || dn[d] !== 1'b0 || v2[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state STEP=%0d: busy=%b done=%b val2=%h, required 0 0 00000000",
                         step_of(d), bz[d], dn[d], v2[d]);
            end
        end
        // First start right on the edge after reset release.
        rst = 1'b0; start = 1'b1; Val_Rm = 32'h1234_5678; Shift_operand = 12'h000;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dn[d] !== 1'b1 || v2[d] !== 32'h1234_5678) begin
                errors++;
                $display("FAIL first_start STEP=%0d: done=%b val2=%h, required 1 12345678",
                         step_of(d), dn[d], v2[d]);
            end
        end
    endtask

    task automatic test_directed();
        run_op("ror_imm",   1'b1, 1'b0, 32'h0,        12'h4FF, 1'b1, 32'hFF00_0000, 0);
        run_op("ror_v2src", 1'b0, 1'b1, 32'hFFFF_FFFF, 12'h4FF, 1'b1, 32'hFF00_0000, 0);
        run_op("asr4",      1'b0, 1'b0, 32'h8000_0010, 12'h240, 1'b1, 32'hF800_0001, 0);
        run_op("lsr4",      1'b0, 1'b0, 32'h8000_0010, 12'h220, 1'b1, 32'h0800_0001, 0);
        run_op("ror31",     1'b0, 1'b0, 32'h0000_0001, 12'hFE0, 1'b1, 32'h0000_0002, 0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; Imm = 1'b0; Val2_Src = 1'b0; Val_Rm = 32'hDEAD_BEEF; Shift_operand = 12'h000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dn[d] !== 1'b1 || v2[d] !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL b2b_first STEP=%0d: done=%b val2=%h, required 1 deadbeef",
                         step_of(d), dn[d], v2[d]);
            end
        end
        Val_Rm = 32'h1; Shift_operand = 12'h080;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bz[d] !== 1'b1 || dn[d] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_no_bubble STEP=%0d: busy=%b done=%b, required 1 0",
                         step_of(d), bz[d], dn[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dn[d] !== 1'b1 || v2[d] !== 32'h2) begin
                errors++;
                $display("FAIL b2b_second STEP=%0d: done=%b val2=%h, required 1 00000002",
                         step_of(d), dn[d], v2[d]);
            end
            last_v2[d] = v2[d];
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        run_op("busy_ignore", 1'b0, 1'b0, 32'h0000_0001, 12'hFE0, 1'b1, 32'h0000_0002, 2);
    endtask

    task automatic test_flush();
        bit got_done [3];
        for (int d = 0; d < 3; d++) got_done[d] = 0;
        @(negedge clk);
        start = 1'b1; Imm = 1'b0; Val2_Src = 1'b0; Val_Rm = 32'hA5A5_0F0F;
        Shift_operand = 12'(20 << 7) | 12'h060;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1; start = 1'b1; Shift_operand = 12'h000;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bz[d] !== 1'b0 || dn[d] !== 1'b0 || v2[d] !== last_v2[d]) begin
                errors++;
                $display("FAIL flush_state STEP=%0d: busy=%b done=%b val2=%h, required 0 0 %h",
                         step_of(d), bz[d], dn[d], v2[d], last_v2[d]);
            end
        end
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (dn[d] === 1'b1) got_done[d] = 1;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got_done[d]) begin
                errors++;
                $display("FAIL flush_no_done STEP=%0d: done pulsed, required none", step_of(d));
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        start = 1'b1; Imm = 1'b0; Val2_Src = 1'b0; Val_Rm = 32'h1; Shift_operand = 12'hFE0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bz[d] !== 1'b0 || dn[d] !== 1'b0 || v2[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_mid_shift STEP=%0d: busy=%b done=%b val2=%h, required 0 0 00000000",
                         step_of(d), bz[d], dn[d], v2[d]);
            end
            last_v2[d] = 32'h0;
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("after_reset", 1'b0, 1'b0, 32'hC000_0003, 12'h1E0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [11:0] so;
        logic        imm_r, v2s_r;
        for (int i = 0; i < 64; i++) begin
            imm_r = ($urandom_range(0, 3) == 0);
            v2s_r = ($urandom_range(0, 5) == 0);
            if (imm_r | v2s_r) so = 12'($urandom);
            else so = {5'(i % 32), 2'($urandom), 5'($urandom)};
            run_op("random", imm_r, v2s_r, $urandom, so, 1'b0, 32'h0, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) last_v2[d] = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_busy_ignore();
        test_flush();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
